// File: rtl/bp_be_fe_queue_pkg.sv
// rtl/bp_be_fe_queue_pkg.sv - configuration enum, FE queue packet layout and width helper
// Purpose: shared types for the BE-side FE queue.
// Contents: bp_params_e (processor configuration selector), bp_fe_queue_s
//           (fetch-to-backend packet), bp_fe_queue_width() (packet width per config).
package bp_be_fe_queue_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  // Fetch packet: message type, virtual PC and the fetched instruction.
  typedef struct packed {
    logic [1:0]  msg_type;
    logic [38:0] pc;
    logic [31:0] instr;
  } bp_fe_queue_s;

  function automatic int bp_fe_queue_width(input bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg: return $bits(bp_fe_queue_s);
      default:          return $bits(bp_fe_queue_s);
    endcase
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - one-write one-read register file with asynchronous read
// Purpose: packet storage for the FE queue; contents are never reset.
// Ports: w_clk_i     write clock
//        w_v_i       write enable
//        w_addr_i    write slot
//        w_data_i    write data
//        r_addr_i    read slot
//        r_data_o    read data, combinational from the array
module bsg_mem_1r1w #(
  parameter int width_p = 1,
  parameter int els_p   = 2,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue.sv
// rtl/bp_be_fe_queue.sv - speculative FE queue with commit, roll and clear
// Purpose: buffers fetch packets; entries are dequeued speculatively and only
//          freed on commit, so a roll can replay everything since the last commit.
// Ports: clk_i                 clock
//        reset_n_i             asynchronous active-low reset
//        fe_queue_i/_v_i       incoming packet and valid
//        fe_queue_ready_and_o  space available (not full)
//        fe_queue_o/_v_o       packet at the speculative read pointer and valid
//        fe_queue_yumi_i       consumer takes fe_queue_o
//        commit_i              oldest dequeued entry retires
//        roll_i                replay dequeued, uncommitted entries
//        clr_i                 discard everything
//        empty_o               no unread entries
module bp_be_fe_queue
  import bp_be_fe_queue_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 8,
  localparam int fe_queue_width_lp = bp_fe_queue_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_and_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         commit_i,
  input  logic                         roll_i,
  input  logic                         clr_i,
  output logic                         empty_o
);

  localparam int ptr_width_lp = $clog2(els_p) + 1;

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic full, enq;

  // The extra wrap bit lets wptr - cptr reach els_p without aliasing empty.
  assign full                 = (wptr - cptr) == ptr_width_lp'(els_p);
  assign fe_queue_ready_and_o = ~full;
  assign fe_queue_v_o         = (rptr != wptr);
  assign empty_o              = ~fe_queue_v_o;
  assign enq                  = fe_queue_v_i & fe_queue_ready_and_o & ~clr_i;

  always_comb begin
    wptr_n = wptr + ptr_width_lp'(enq);
    cptr_n = cptr + ptr_width_lp'(commit_i);
    rptr_n = rptr + ptr_width_lp'(fe_queue_yumi_i);
    if (clr_i) begin
      // Collapse onto the pre-enqueue write pointer; the enqueue is dropped.
      rptr_n = wptr;
      cptr_n = wptr;
    end else if (roll_i) begin
      // Replay starts after anything retiring this same cycle.
      rptr_n = cptr + ptr_width_lp'(commit_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p (fe_queue_width_lp),
    .els_p   (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr[ptr_width_lp-2:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr[ptr_width_lp-2:0]),
    .r_data_o (fe_queue_o)
  );

  // Protocol checks: no yumi without data, no commit of an undequeued entry.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!fe_queue_yumi_i || fe_queue_v_o);
      assert (!commit_i || (cptr != rptr));
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue.sv
// tb/tb_bp_be_fe_queue.sv - self-checking bench for bp_be_fe_queue against a list-based model
module tb_bp_be_fe_queue;
  import bp_be_fe_queue_pkg::*;

  localparam int ELS = 8;
  localparam int W   = bp_fe_queue_width(e_bp_default_cfg);

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] fq_i;
  logic         fq_v_i, yumi, commit, roll, clr;
  logic         ready, fq_v_o, empty;
  logic [W-1:0] fq_o;

  always #5 clk = ~clk;

  bp_be_fe_queue #(
    .bp_params_p (e_bp_default_cfg),
    .els_p       (ELS)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .fe_queue_i           (fq_i),
    .fe_queue_v_i         (fq_v_i),
    .fe_queue_ready_and_o (ready),
    .fe_queue_o           (fq_o),
    .fe_queue_v_o         (fq_v_o),
    .fe_queue_yumi_i      (yumi),
    .commit_i             (commit),
    .roll_i               (roll),
    .clr_i                (clr),
    .empty_o              (empty)
  );

  int total = 0;
  int bad   = 0;

  // Model: mq holds every uncommitted packet oldest first; rd counts how many
  // of those have been handed to the consumer since the last commit point.
  logic [W-1:0] mq[$];
  int           rd = 0;

  function automatic logic [W-1:0] pkt(input logic [38:0] pc);
    bp_fe_queue_s s;
    s          = '0;
    s.pc       = pc;
    s.instr    = pc[31:0] ^ 32'h0000_0013;
    s.msg_type = pc[3:2];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic m_v;
    m_v = (rd < mq.size());
    chk1({tag, ":ready"}, ready, mq.size() < ELS);
    chk1({tag, ":v"}, fq_v_o, m_v);
    chk1({tag, ":empty"}, empty, !m_v);
    if (m_v) chk({tag, ":data"}, fq_o, mq[rd]);
  endtask

  // Called at posedge+1: drive, check outputs mid-cycle, clock, update model.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                      input logic y, input logic c, input logic r, input logic cl);
    logic acc;
    fq_v_i = v; fq_i = d; yumi = y; commit = c; roll = r; clr = cl;
    #1;
    check_model(tag);
    acc = v && (mq.size() < ELS) && !cl;
    @(posedge clk);
    if (cl) begin
      mq.delete();
      rd = 0;
    end else begin
      if (c) begin
        void'(mq.pop_front());
        rd--;
      end
      if (r) rd = 0;
      else if (y) rd++;
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pa, pb, pc, pd;
    logic         y, c, r, cl, v;
    fq_i = '0; fq_v_i = 0; yumi = 0; commit = 0; roll = 0; clr = 0;
    reset_n = 1'b0;
    #7;
    chk1("reset_ready", ready, 1'b1);
    chk1("reset_v", fq_v_o, 1'b0);
    chk1("reset_empty", empty, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Fill to capacity with no dequeues; the ninth packet must be refused.
    for (int i = 0; i < ELS; i++) step("fill", 1'b1, pkt(39'h1000 + 39'(4*i)), 0, 0, 0, 0);
    chk1("fill_full_ready", ready, 1'b0);
    chk1("fill_v", fq_v_o, 1'b1);
    chk("fill_head", fq_o, pkt(39'h1000));
    step("fill_ninth", 1'b1, pkt(39'h1020), 0, 0, 0, 0);

    // Dequeue everything; slots stay held until commit.
    for (int i = 0; i < ELS; i++) step("deq", 1'b0, '0, 1'b1, 0, 0, 0);
    chk1("hold_v", fq_v_o, 1'b0);
    chk1("hold_ready", ready, 1'b0);
    step("commit1", 1'b0, '0, 0, 1'b1, 0, 0);
    chk1("commit_ready", ready, 1'b1);
    for (int i = 1; i < ELS; i++) step("drain", 1'b0, '0, 0, 1'b1, 0, 0);

    // Roll: replay B and C after A has retired.
    pa = pkt(39'h2000); pb = pkt(39'h2004); pc = pkt(39'h2008); pd = pkt(39'h3000);
    step("roll_enqA", 1'b1, pa, 0, 0, 0, 0);
    step("roll_enqB", 1'b1, pb, 0, 0, 0, 0);
    step("roll_enqC", 1'b1, pc, 0, 0, 0, 0);
    step("roll_yA", 1'b0, '0, 1'b1, 0, 0, 0);
    step("roll_yB", 1'b0, '0, 1'b1, 0, 0, 0);
    step("roll_cA", 1'b0, '0, 0, 1'b1, 0, 0);
    step("roll", 1'b0, '0, 0, 0, 1'b1, 0);
    chk("roll_B", fq_o, pb);
    step("roll_yB2", 1'b0, '0, 1'b1, 0, 0, 0);
    chk("roll_C", fq_o, pc);
    step("roll_yC2", 1'b0, '0, 1'b1, 0, 0, 0);
    step("roll_cB", 1'b0, '0, 0, 1'b1, 0, 0);
    step("roll_cC", 1'b0, '0, 0, 1'b1, 0, 0);

    // Clear with a simultaneous enqueue of D; D must never appear.
    for (int i = 0; i < 5; i++) step("clr_fill", 1'b1, pkt(39'h4000 + 39'(4*i)), 0, 0, 0, 0);
    step("clr_y0", 1'b0, '0, 1'b1, 0, 0, 0);
    step("clr_y1", 1'b0, '0, 1'b1, 0, 0, 0);
    step("clr", 1'b1, pd, 0, 0, 0, 1'b1);
    chk1("clr_empty", empty, 1'b1);
    chk1("clr_ready", ready, 1'b1);
    for (int i = 0; i < 3; i++) idle("clr_after");

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      y  = (rd < mq.size()) && ($urandom_range(0, 2) != 0);
      c  = (rd > 0) && ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 79) == 0);
      step("rand", v, pkt({7'h0, $urandom()}), y, c, r, cl);
    end

    // Asynchronous reset mid-cycle with three entries buffered.
    step("ar_clr", 1'b0, '0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step("ar_enq", 1'b1, pkt(39'h5000 + 39'(4*i)), 0, 0, 0, 0);
    fq_v_i = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk1("ar_v", fq_v_o, 1'b0);
    chk1("ar_empty", empty, 1'b1);
    chk1("ar_ready", ready, 1'b1);
    mq.delete();
    rd = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle("ar_after");
    idle("ar_after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
